mont_domain_conv: RTL

//  Sequencer that drives the montgomery multiplier. It converts an operand into or out of the Montgomery domain.
//  - to-Mont:   res = x*R mod M, computed as MontMul(x, R2)
//  - from-Mont: res = x*R^-1 mod M, computed as MontMul(x, 1)

---
 rtl/mont_domain_conv.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mont_domain_conv.sv
// Montgomery domain converter: pre-reduce x, MontMul(x, R2 or 1), post-reduce; start->mont_start CHUNKS+1 cycles, mont_done->done CHUNKS+1.
// No backpressure: start is taken only in IDLE; the multiplier result is held by mont_done until mont_out_read.
`timescale 1ns/1ps
module mont_domain_conv #(
   parameter int WIDTH   = 381,
   parameter int CHUNK_W = 127
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_m,
   input  logic [WIDTH-1:0] in_r2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             mont_start,
   output logic [WIDTH-1:0] mont_a,
   output logic [WIDTH-1:0] mont_b,
   output logic [WIDTH-1:0] mont_m,
   output logic             mont_out_read,
   input  logic [WIDTH-1:0] mont_result,
   input  logic             mont_done
);

   localparam int CHUNKS = WIDTH / CHUNK_W;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_MSTART, S_MWAIT, S_POST, S_FIN
   } state_t;

   state_t           state_q;
   logic             mode_q;
   logic [WIDTH-1:0] m_q, r2_q, v_q, d_q;
   logic             borrow_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, mont_start_q, mont_out_read_q;
   logic [WIDTH-1:0] result_q, mont_a_q, mont_b_q, mont_m_q;

   // One slice of d = v - M per cycle; the borrow ripples through borrow_q.
   logic [CHUNK_W-1:0] v_sl, m_sl;
   logic [CHUNK_W:0]   sub;
   logic [WIDTH-1:0]   d_d;
   logic               last_sl;
   int                 base;

   always_comb begin
      base    = int'(cnt_q) * CHUNK_W;
      v_sl    = v_q[base +: CHUNK_W];
      m_sl    = m_q[base +: CHUNK_W];
      sub     = {1'b0, v_sl} - {1'b0, m_sl} - {{CHUNK_W{1'b0}}, borrow_q};
      d_d     = d_q;
      d_d[base +: CHUNK_W] = sub[CHUNK_W-1:0];
      last_sl = (cnt_q == CW'(CHUNKS - 1));
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q         <= S_IDLE;
         mode_q          <= 1'b0;
         m_q             <= '0;
         r2_q            <= '0;
         v_q             <= '0;
         d_q             <= '0;
         borrow_q        <= 1'b0;
         cnt_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         mont_start_q    <= 1'b0;
         mont_out_read_q <= 1'b0;
         result_q        <= '0;
         mont_a_q        <= '0;
         mont_b_q        <= '0;
         mont_m_q        <= '0;
      end else begin
         done_q          <= 1'b0;
         mont_start_q    <= 1'b0;
         mont_out_read_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  mode_q   <= mode;
                  v_q      <= in_x;
                  m_q      <= in_m;
                  r2_q     <= in_r2;
                  cnt_q    <= '0;
                  borrow_q <= 1'b0;
                  busy_q   <= 1'b1;
                  state_q  <= S_PRE;
               end
            end
            S_PRE, S_POST: begin
               d_q      <= d_d;
               borrow_q <= sub[CHUNK_W];
               cnt_q    <= cnt_q + CW'(1);
               if (last_sl) begin
                  // Input is below 2M, so one conditional subtract fully reduces it.
                  if (!sub[CHUNK_W]) v_q <= d_d;
                  cnt_q   <= '0;
                  state_q <= (state_q == S_PRE) ? S_MSTART : S_FIN;
               end
            end
            S_MSTART: begin
               mont_a_q     <= v_q;
               mont_b_q     <= mode_q ? {{(WIDTH-1){1'b0}}, 1'b1} : r2_q;
               mont_m_q     <= m_q;
               mont_start_q <= 1'b1;
               state_q      <= S_MWAIT;
            end
            S_MWAIT: begin
               if (mont_done) begin
                  v_q             <= mont_result;
                  borrow_q        <= 1'b0;
                  cnt_q           <= '0;
                  mont_out_read_q <= 1'b1;
                  state_q         <= S_POST;
               end
            end
            S_FIN: begin
               result_q <= v_q;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign result        = result_q;
   assign mont_start    = mont_start_q;
   assign mont_a        = mont_a_q;
   assign mont_b        = mont_b_q;
   assign mont_m        = mont_m_q;
   assign mont_out_read = mont_out_read_q;

endmodule
